// File: rtl/uart_parity_odd_tx_if.sv
// Load-side handshake bundle for uart_parity_odd_tx.
//
// Handshake: the transmitter raises `ready` whenever its one-word holding
// buffer is empty. A word is transferred on every rising clock edge at which
// `load && ready` is true; `data_in` is sampled only on that edge. A `load`
// while `ready` is low is simply ignored. The producer may change `data_in`
// freely once the transfer edge has passed.
//
// Signals:
//   data_in [DATA_W] : word to transmit (master -> slave)
//   load             : transfer request  (master -> slave)
//   ready            : holding buffer empty (slave -> master)
interface uart_parity_odd_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              ready;

  modport master (output data_in, output load, input ready);
  modport slave  (input data_in, input load, output ready);
endinterface

// File: rtl/uart_parity_odd_tx.sv
// Odd-parity UART-style serializer.
//
// Buffers one word from the load handshake, then shifts out a frame on
// `signal`: start bit (1), DATA_W data bits LSB first, one odd-parity bit,
// then GAP_BITS idle bit periods (line low). Each bit lasts BIT_CYCLES
// clocks. The holding buffer frees up as soon as a word is moved into the
// shifter, so the next word can be queued while a frame is in flight and
// frames run back-to-back separated only by the gap.
//
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous, active-low
//   bus         : slave side of the load handshake (data_in, load, ready)
//   signal      : registered serial line, idle 0
//   busy        : high from start bit through last gap cycle
//   frame_done  : one-cycle pulse in the first gap cycle of each frame
//   o_dbg_state : current FSM state (encoding of state_e)
module uart_parity_odd_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_parity_odd_tx_if.slave  bus,
  output logic                 signal,
  output logic                 busy,
  output logic                 frame_done,
  output logic [2:0]           o_dbg_state
);

  localparam int IDX_MAX = (DATA_W > GAP_BITS) ? DATA_W : GAP_BITS;
  localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
  localparam int CYC_W   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_GAP    = 3'd4
  } state_e;

  state_e             r_state;
  logic [DATA_W-1:0]  r_hold;
  logic               r_hold_full;
  logic [DATA_W-1:0]  r_shift;
  logic               r_parity;
  logic [CYC_W-1:0]   r_cyc;
  logic [IDX_W-1:0]   r_idx;
  logic               r_signal;
  logic               r_busy;
  logic               r_frame_done;

  state_e             w_state_n;
  logic               w_hold_full_n;
  logic [DATA_W-1:0]  w_shift_n;
  logic               w_parity_n;
  logic [CYC_W-1:0]   w_cyc_n;
  logic [IDX_W-1:0]   w_idx_n;
  logic               w_accept;
  logic               w_pop;
  logic               w_bit_end;
  logic               w_signal_n;

  assign bus.ready   = ~r_hold_full;
  assign w_accept    = bus.load & ~r_hold_full;
  assign w_bit_end   = (r_cyc == CYC_W'(BIT_CYCLES - 1));

  assign signal      = r_signal;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign o_dbg_state = r_state;

  // Next-state and next-datapath logic.
  always_comb begin
    w_state_n     = r_state;
    w_shift_n     = r_shift;
    w_parity_n    = r_parity;
    w_cyc_n       = r_cyc;
    w_idx_n       = r_idx;
    w_pop         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_hold_full) w_pop = 1'b1;
      end
      S_START: begin
        if (w_bit_end) begin
          w_cyc_n   = '0;
          w_state_n = S_DATA;
        end else begin
          w_cyc_n = r_cyc + CYC_W'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cyc_n   = '0;
          w_shift_n = r_shift >> 1;
          if (r_idx == IDX_W'(DATA_W - 1)) begin
            w_idx_n   = '0;
            w_state_n = S_PARITY;
          end else begin
            w_idx_n = r_idx + IDX_W'(1);
          end
        end else begin
          w_cyc_n = r_cyc + CYC_W'(1);
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_cyc_n   = '0;
          w_idx_n   = '0;
          w_state_n = S_GAP;
        end else begin
          w_cyc_n = r_cyc + CYC_W'(1);
        end
      end
      S_GAP: begin
        if (w_bit_end) begin
          w_cyc_n = '0;
          if (r_idx == IDX_W'(GAP_BITS - 1)) begin
            w_idx_n = '0;
            // A queued word starts right after the last gap cycle.
            if (r_hold_full) w_pop = 1'b1;
            else             w_state_n = S_IDLE;
          end else begin
            w_idx_n = r_idx + IDX_W'(1);
          end
        end else begin
          w_cyc_n = r_cyc + CYC_W'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_pop) begin
      w_shift_n  = r_hold;
      w_parity_n = ~^r_hold;
      w_cyc_n    = '0;
      w_idx_n    = '0;
      w_state_n  = S_START;
    end

    // Pop and accept are mutually exclusive: accept needs the buffer empty,
    // pop needs it full.
    w_hold_full_n = r_hold_full;
    if (w_pop)    w_hold_full_n = 1'b0;
    if (w_accept) w_hold_full_n = 1'b1;

    // Line level is registered from the state being entered, so the start
    // bit appears on the edge that pops the buffer.
    w_signal_n = 1'b0;
    case (w_state_n)
      S_START:  w_signal_n = 1'b1;
      S_DATA:   w_signal_n = w_shift_n[0];
      S_PARITY: w_signal_n = w_parity_n;
      default:  w_signal_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_cyc        <= '0;
      r_idx        <= '0;
      r_signal     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_hold_full  <= w_hold_full_n;
      r_shift      <= w_shift_n;
      r_parity     <= w_parity_n;
      r_cyc        <= w_cyc_n;
      r_idx        <= w_idx_n;
      r_signal     <= w_signal_n;
      r_busy       <= (w_state_n != S_IDLE);
      // GAP is only ever entered from PARITY, so this marks its first cycle.
      r_frame_done <= (w_state_n == S_GAP) && (r_state != S_GAP);
      if (w_accept) r_hold <= bus.data_in;
    end
  end

endmodule

// File: tb/tb_uart_parity_odd_tx.sv
module tb_uart_parity_odd_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_parity_odd_tx_if #(.DATA_W(8)) if0 ();
  uart_parity_odd_tx_if #(.DATA_W(8)) if3 ();

  logic       sig0, busy0, fd0;
  logic [2:0] st0;
  logic       sig3, busy3, fd3;
  logic [2:0] st3;

  uart_parity_odd_tx #(.DATA_W(8), .BIT_CYCLES(1), .GAP_BITS(1)) u_dut (
    .clk(clk), .reset(reset), .bus(if0.slave),
    .signal(sig0), .busy(busy0), .frame_done(fd0), .o_dbg_state(st0)
  );

  uart_parity_odd_tx #(.DATA_W(8), .BIT_CYCLES(3), .GAP_BITS(2)) u_dut3 (
    .clk(clk), .reset(reset), .bus(if3.slave),
    .signal(sig3), .busy(busy3), .frame_done(fd3), .o_dbg_state(st3)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  data;
    logic [10:0] seq;   // seq[t] = expected line level t cycles after the pop
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] d);
    int n;
    n = 0;
    while (if0.ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("load_wait_ready", {31'd0, if0.ready}, 32'd1);
    if0.data_in = d;
    if0.load    = 1'b1;
    exp_q.push_back(d);
    tick();
    if0.load    = 1'b0;
    if0.data_in = 8'($urandom_range(0, 255));
    chk("ready_after_accept", {31'd0, if0.ready}, 32'd0);
  endtask

  task automatic frame(input logic [10:0] seq, input bit mid, input logic [7:0] mid_d);
    for (int t = 0; t < 11; t++) begin
      tick();
      chk($sformatf("sig t=%0d", t),   {31'd0, sig0},  {31'd0, seq[t]});
      chk($sformatf("busy t=%0d", t),  {31'd0, busy0}, 32'd1);
      chk($sformatf("fd t=%0d", t),    {31'd0, fd0},   (t == 10) ? 32'd1 : 32'd0);
      chk($sformatf("ready t=%0d", t), {31'd0, if0.ready}, (mid && t >= 1) ? 32'd0 : 32'd1);
      if (mid && t == 0) begin
        if0.data_in = mid_d;
        if0.load    = 1'b1;
        exp_q.push_back(mid_d);
      end
      if (mid && t == 1) begin
        if0.load    = 1'b0;
        if0.data_in = 8'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic idle_check(input string nm);
    tick();
    chk({nm, "_busy"},  {31'd0, busy0}, 32'd0);
    chk({nm, "_sig"},   {31'd0, sig0},  32'd0);
    chk({nm, "_fd"},    {31'd0, fd0},   32'd0);
    chk({nm, "_ready"}, {31'd0, if0.ready}, 32'd1);
  endtask

  // Loopback odd-parity receiver on the default-configuration line.
  int         rx_ph = 0;
  int         rx_n  = 0;
  logic [8:0] rx_bits;
  int         rx_valid = 0;
  int         rx_err   = 0;

  always @(negedge clk) begin
    if (!reset) begin
      rx_ph = 0;
    end else begin
      case (rx_ph)
        0: if (sig0 === 1'b1) begin rx_ph = 1; rx_n = 0; end
        1: begin
          rx_bits[rx_n] = sig0;
          rx_n++;
          if (rx_n == 9) rx_ph = 2;
        end
        default: begin
          if (sig0 !== 1'b0 || (^rx_bits) !== 1'b1) begin
            rx_err++;
          end else begin
            rx_valid++;
            chk("loopback_q_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) chk("loopback_data", {24'd0, rx_bits[7:0]}, {24'd0, exp_q.pop_front()});
          end
          rx_ph = 0;
        end
      endcase
    end
  end

  logic [10:0] seq80;

  initial begin
    vecs[0] = '{8'h00, 11'h201};
    vecs[1] = '{8'hA5, 11'h34B};
    vecs[2] = '{8'hFF, 11'h3FF};
    vecs[3] = '{8'h01, 11'h003};
    vecs[4] = '{8'h7F, 11'h0FF};
    seq80   = 11'h101;

    reset       = 1'b0;
    if0.load    = 1'b0;
    if0.data_in = '0;
    if3.load    = 1'b0;
    if3.data_in = '0;
    tick(); tick(); tick();
    chk("rst_sig",    {31'd0, sig0},  32'd0);
    chk("rst_busy",   {31'd0, busy0}, 32'd0);
    chk("rst_fd",     {31'd0, fd0},   32'd0);
    chk("rst_ready",  {31'd0, if0.ready}, 32'd1);
    chk("rst_state",  {29'd0, st0},   32'd0);
    chk("rst_ready3", {31'd0, if3.ready}, 32'd1);
    reset = 1'b1;

    // Table-driven single frames.
    for (int i = 0; i < 5; i++) begin
      load_word(vecs[i].data);
      frame(vecs[i].seq, 1'b0, 8'h00);
      idle_check($sformatf("idle_v%0d", i));
    end

    // Back-to-back: 0x81 accepted during the 0x3C frame.
    load_word(8'h3C);
    frame(11'h279, 1'b1, 8'h81);
    frame(11'h303, 1'b0, 8'h00);
    idle_check("idle_b2b");

    // Reset during DATA with a word buffered.
    load_word(8'h5A);
    tick();
    if0.data_in = 8'h77;
    if0.load    = 1'b1;
    tick();
    if0.load    = 1'b0;
    chk("mid_ready_full", {31'd0, if0.ready}, 32'd0);
    tick();
    chk("pre_reset_sig", {31'd0, sig0}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_sig",   {31'd0, sig0},  32'd0);
    chk("mid_rst_ready", {31'd0, if0.ready}, 32'd1);
    chk("mid_rst_busy",  {31'd0, busy0}, 32'd0);
    chk("mid_rst_fd",    {31'd0, fd0},   32'd0);
    chk("mid_rst_state", {29'd0, st0},   32'd0);
    exp_q.delete();
    tick();
    chk("rst_hold_fd", {31'd0, fd0}, 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("post_rst_sig c%0d", i),  {31'd0, sig0},  32'd0);
      chk($sformatf("post_rst_busy c%0d", i), {31'd0, busy0}, 32'd0);
      chk($sformatf("post_rst_fd c%0d", i),   {31'd0, fd0},   32'd0);
    end
    load_word(8'h12);
    frame(11'h225, 1'b0, 8'h00);
    idle_check("idle_after_rst");

    // BIT_CYCLES=3, GAP_BITS=2 instance.
    if3.data_in = 8'h80;
    if3.load    = 1'b1;
    tick();
    if3.load    = 1'b0;
    if3.data_in = 8'($urandom_range(0, 255));
    chk("bc3_ready_full", {31'd0, if3.ready}, 32'd0);
    for (int t = 0; t < 36; t++) begin
      tick();
      chk($sformatf("bc3 sig t=%0d", t),  {31'd0, sig3}, (t < 30) ? {31'd0, seq80[t / 3]} : 32'd0);
      chk($sformatf("bc3 busy t=%0d", t), {31'd0, busy3}, 32'd1);
      chk($sformatf("bc3 fd t=%0d", t),   {31'd0, fd3}, (t == 30) ? 32'd1 : 32'd0);
    end
    tick();
    chk("bc3_idle_busy", {31'd0, busy3}, 32'd0);
    chk("bc3_idle_fd",   {31'd0, fd3},   32'd0);
    chk("bc3_idle_sig",  {31'd0, sig3},  32'd0);
    chk("bc3_idle_ready", {31'd0, if3.ready}, 32'd1);

    tick(); tick();
    chk("loopback_err",   rx_err,   32'd0);
    chk("loopback_valid", rx_valid, 32'd8);
    chk("loopback_q_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_parity_odd_tx.md
# uart_parity_odd_tx

- Upstream serializer for the odd-parity UART checker stage.
- Accepts a parallel data word through a ready/load handshake and buffers one word. It then emits a framed serial bit stream on `signal`: start bit, data bits LSB first, one odd-parity bit, then idle gap.
- Buffering lets the next word be accepted while the current frame shifts out, so frames run back-to-back with only the configured gap between them.

## Interface
- `DATA_W`, default 8: data bits per frame (≥1).
- `BIT_CYCLES`, default 1: clock cycles each serial bit is held (≥1).
- `GAP_BITS`, default 1: idle bit periods (line low) after each parity bit (≥1).

- `clk` in 1: clock; all state changes on its rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `data_in` in DATA_W: word to transmit; sampled when `load && ready`.
- `load` in 1: request to accept `data_in`.
- `ready` out 1: holding buffer empty; a word is accepted at the rising edge where `load && ready`.
- `signal` out 1: serial line, registered; idle level 0.
- `busy` out 1: high from the start bit through the last gap cycle of a frame.
- `frame_done` out 1: one-cycle pulse in the first gap cycle after a parity bit.

## Operation
- Storage:
  - Holding register `hold` with flag `hold_full`.
  - Shift register of DATA_W bits.
  - Bit-period counter 0..BIT_CYCLES-1.
  - Bit index counter 0..max(DATA_W, GAP_BITS)-1.
- `ready = !hold_full` (combinational from the flag).
- `load` while `ready=0` is ignored; `data_in` is not sampled.
- Parity bit = `~^data`, so the data bits plus parity always contain an odd number of ones.
- FSM states and transitions:
  - IDLE: `signal=0`, `busy=0`. If `hold_full` → pop `hold` into the shifter, compute parity, clear `hold_full`, go to START.
  - START: `signal=1` for one bit period → DATA.
  - DATA: `signal=shifter[0]`, shift right at the end of each bit period. After DATA_W periods → PARITY.
  - PARITY: `signal=parity` for one bit period → GAP.
  - GAP: `signal=0` for GAP_BITS periods; `frame_done=1` in its first cycle. At the end, if `hold_full` → pop and go to START (same rules as IDLE); else → IDLE.
- Simultaneous pop and load in one cycle cannot occur, because `ready=0` while `hold_full`.
- A load during any frame state fills `hold` and does not disturb the frame in flight.
- `data_in` changes after acceptance do not affect a buffered or shifting word.
- Reset values (asserted, asynchronous):
  - `signal=0`, `busy=0`, `frame_done=0`, `ready=1`.
  - `hold_full=0`; FSM=IDLE; counters=0.
- Reset mid-frame: the frame is truncated immediately, the buffered word is discarded, and no `frame_done` is issued.

## Timing
- Load accepted at edge k with the shifter idle:
  - edge k+1: IDLE pops `hold`.
  - Start bit appears on `signal` after edge k+1.
  - Latency from acceptance to start bit is 1 cycle.
- `ready` returns high in the cycle after the pop (after edge k+1).
- Frame length = (DATA_W+2)·BIT_CYCLES cycles of start/data/parity, plus GAP_BITS·BIT_CYCLES gap cycles.
- Defaults: 10 active cycles plus 1 gap cycle.
- Back-to-back: with `hold_full` at the end of GAP, the next start bit follows the last gap cycle directly. No extra IDLE cycle is inserted.
- Default throughput: one frame every 11 cycles.
- `busy` rises with the start bit and falls in the cycle after the last gap cycle, unless the next frame starts.
- `frame_done` is high exactly one cycle per completed frame, regardless of BIT_CYCLES.
- Reset release: first acceptance is possible at the first rising edge where `reset=1`.

## Test plan
- Defaults; load 0x00 once → `signal` after the pop cycle is 1, 0×8, 1 (parity), 0; `frame_done` pulses on the 0 gap cycle; `busy` is high for 11 cycles.
- Load 0xA5 (LSB first: 1,0,1,0,0,1,0,1; 4 ones) → 1,1,0,1,0,0,1,0,1,1(parity),0.
- Load 0xFF → parity 1; load 0x01 → parity 0.
- Back-to-back, loads of 0x3C then 0x81, second accepted mid-frame:
  - `ready` is 0 from the second acceptance until the pop at end of GAP.
  - The second start bit immediately follows the single gap cycle; frames are 11 cycles apart.
  - `frame_done` pulses twice.
- Assert `reset` during DATA of frame 0x5A with 0x77 buffered:
  - `signal=0` and `ready=1` immediately; no `frame_done`.
  - After release, load 0x12 → a clean frame with parity 1.
- BIT_CYCLES=3, GAP_BITS=2; load 0x80:
  - Each bit is held 3 cycles; 30 active cycles, then 6 gap cycles.
  - `frame_done` pulses once on the first gap cycle.
- Loopback, defaults: drive the odd-parity checker with `signal` for 0x00, 0xA5 and 0xFF → the checker reports valid and never error.
